// File: rtl/fb_access_arbiter.sv
// Frame-buffer access arbiter: the video fetch path always wins the RAM slot;
// two pixel writers share the cycles it leaves free, round-robin.
module fb_access_arbiter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [9:0]        vid_x,
  input  logic [8:0]        vid_y,
  output logic [7:0]        vid_r,
  output logic [7:0]        vid_g,
  output logic [7:0]        vid_b,
  output logic              vid_valid,
  input  logic [1:0]        wr_req,
  input  logic [19:0]       wr_x,
  input  logic [17:0]       wr_y,
  input  logic [47:0]       wr_data,
  output logic [1:0]        wr_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       drop_cnt
);

  localparam logic [31:0] LP_W = WIDTH;
  localparam logic [31:0] LP_H = HEIGHT;

  // Writer handshake: a writer raises wr_req[i] with x/y/data and holds them
  // until wr_gnt[i] is high in the same cycle; that cycle commits the write.
  logic              r_ptr;
  logic              r_v1, r_oor1, r_v2, r_oor2;
  logic [23:0]       r_hold;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [15:0]       r_drop;

  logic              w_any, w_win, w_inr;
  logic [9:0]        w_x, w_sel_x;
  logic [8:0]        w_y, w_sel_y;
  logic [23:0]       w_sel_d, w_pix;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_gnt;

  assign w_any   = |wr_req;
  // Winner is the first requester found scanning from the pointer.
  assign w_win   = r_ptr ? wr_req[1] : ~wr_req[0];
  assign w_sel_x = w_win ? wr_x[19:10]    : wr_x[9:0];
  assign w_sel_y = w_win ? wr_y[17:9]     : wr_y[8:0];
  assign w_sel_d = w_win ? wr_data[47:24] : wr_data[23:0];

  assign w_x    = vid_req ? vid_x : w_sel_x;
  assign w_y    = vid_req ? vid_y : w_sel_y;
  assign w_inr  = (32'(w_x) < LP_W) && (32'(w_y) < LP_H);
  assign w_addr = ADDR_W'(32'(w_y) * LP_W + 32'(w_x));

  assign w_gnt  = (!vid_req && w_any) ? (w_win ? 2'b10 : 2'b01) : 2'b00;
  assign wr_gnt = reset ? w_gnt : 2'b00;

  // RAM data arrives in the cycle after the address; out-of-range slots read black.
  assign w_pix     = r_v2 ? (r_oor2 ? 24'h0 : mem_rdata[23:0]) : r_hold;
  assign vid_r     = w_pix[23:16];
  assign vid_g     = w_pix[15:8];
  assign vid_b     = w_pix[7:0];
  assign vid_valid = r_v2;

  assign mem_addr  = r_addr;
  assign mem_we    = r_we;
  assign mem_wdata = r_wdata;
  assign drop_cnt  = r_drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= 1'b0;
      r_v1    <= 1'b0;
      r_oor1  <= 1'b0;
      r_v2    <= 1'b0;
      r_oor2  <= 1'b0;
      r_hold  <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_drop  <= '0;
    end else begin
      r_we   <= 1'b0;
      r_v1   <= vid_req;
      r_oor1 <= vid_req && !w_inr;
      r_v2   <= r_v1;
      r_oor2 <= r_oor1;
      if (r_v2) r_hold <= w_pix;
      if (vid_req) begin
        if (w_inr) r_addr <= w_addr;
      end else if (w_any) begin
        r_ptr <= ~w_win;
        if (w_inr) begin
          r_we    <= 1'b1;
          r_addr  <= w_addr;
          r_wdata <= DATA_W'(w_sel_d);
        end else if (r_drop != 16'hFFFF) begin
          r_drop <= r_drop + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Bench for fb_access_arbiter: directed cases plus randomized traffic checked
// against a frame-buffer model and an expected-pixel queue.
module tb_fb_access_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        vid_req;
  logic [9:0]  vid_x;
  logic [8:0]  vid_y;
  logic [7:0]  vid_r, vid_g, vid_b;
  logic        vid_valid;
  logic [1:0]  wr_req;
  logic [19:0] wr_x;
  logic [17:0] wr_y;
  logic [47:0] wr_data;
  logic [1:0]  wr_gnt;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic [15:0] drop_cnt;

  fb_access_arbiter dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_x(vid_x), .vid_y(vid_y),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b), .vid_valid(vid_valid),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_gnt(wr_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .drop_cnt(drop_cnt)
  );

  // clock: 25 MHz pixel clock
  always #20 clk = ~clk;

  function automatic logic [23:0] pat(int i);
    return (i == 323) ? 24'h123456 : 24'((i * 40503) ^ 5937842);
  endfunction

  // Synchronous single-port RAM, loaded with the initial pattern on the first edge.
  logic [23:0] ram [0:32767];
  bit          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 32768; i++) ram[i] <= pat(i);
      ram_loaded <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  // reference model state
  logic [23:0] ref_mem [0:32767];
  logic [23:0] exp_q[$];
  int          m_ptr;
  logic        m_prev_req;
  logic        m_exp_we;
  logic [14:0] m_exp_addr;
  logic [23:0] m_exp_wdata;
  logic [15:0] m_drop;
  logic [23:0] m_last_pix;
  logic [1:0]  last_gnt;
  logic [1:0]  obs_gnt;
  int          we_seen;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(int x, int y);
    return (x < 160) && (y < 120);
  endfunction

  function automatic int addr_of(int x, int y);
    return (y * 160 + x) & 32'h7FFF;
  endfunction

  task automatic m_reset();
    m_ptr       = 0;
    m_prev_req  = 1'b0;
    m_exp_we    = 1'b0;
    m_exp_addr  = '0;
    m_exp_wdata = '0;
    m_drop      = '0;
    m_last_pix  = '0;
    last_gnt    = '0;
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, vid_valid, 0);
    chk({tag, "_rgb"}, {vid_r, vid_g, vid_b}, 0);
    chk({tag, "_gnt"}, wr_gnt, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
  endtask

  // One pixel clock: predict the slot outcome, check grant before the edge,
  // check RAM controls and video return after it.
  task automatic step();
    logic [1:0]  g;
    logic [23:0] e;
    logic        exp_valid;
    int          p, wx, wy, a;
    @(negedge clk);
    g = 2'b00;
    if (vid_req) begin
      if (in_range(vid_x, vid_y)) begin
        a = addr_of(vid_x, vid_y);
        m_exp_addr = 15'(a);
        exp_q.push_back(ref_mem[a]);
      end else begin
        exp_q.push_back(24'h0);
      end
      m_exp_we = 1'b0;
    end else if (wr_req != 2'b00) begin
      p = m_ptr;
      if (!wr_req[p]) p = 1 - p;
      g[p]  = 1'b1;
      m_ptr = 1 - p;
      wx = int'(wr_x[p*10 +: 10]);
      wy = int'(wr_y[p*9 +: 9]);
      if (in_range(wx, wy)) begin
        a = addr_of(wx, wy);
        m_exp_we    = 1'b1;
        m_exp_addr  = 15'(a);
        m_exp_wdata = wr_data[p*24 +: 24];
        ref_mem[a]  = m_exp_wdata;
      end else begin
        m_exp_we = 1'b0;
        if (m_drop != 16'hFFFF) m_drop++;
      end
    end else begin
      m_exp_we = 1'b0;
    end
    obs_gnt = wr_gnt;
    chk("wr_gnt", wr_gnt, g);
    last_gnt   = g;
    exp_valid  = m_prev_req;
    m_prev_req = vid_req;
    @(posedge clk);
    #1;
    chk("mem_we", mem_we, m_exp_we);
    chk("mem_addr", mem_addr, m_exp_addr);
    chk("mem_wdata", mem_wdata, m_exp_wdata);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("vid_valid", vid_valid, exp_valid);
    if (exp_valid) begin
      if (exp_q.size() == 0) chk("exp_q_empty", 1, 0);
      else begin
        e = exp_q.pop_front();
        m_last_pix = e;
      end
    end
    chk("vid_rgb", {vid_r, vid_g, vid_b}, m_last_pix);
    if (mem_we) we_seen++;
  endtask

  function automatic int rand_x();
    return $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 175);
  endfunction

  function automatic int rand_y();
    return $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 127);
  endfunction

  task automatic set_writer(input int i, input int x, input int y, input logic [23:0] d);
    wr_x[i*10 +: 10]    = 10'(x);
    wr_y[i*9 +: 9]      = 9'(y);
    wr_data[i*24 +: 24] = d;
  endtask

  // Writers obey the handshake: hold while waiting, decide anew after a grant.
  task automatic drive_random();
    vid_req = ($urandom_range(0, 99) < 45);
    vid_x   = 10'(rand_x());
    vid_y   = 9'(rand_y());
    for (int i = 0; i < 2; i++) begin
      if (last_gnt[i] || !wr_req[i]) begin
        if ($urandom_range(0, 99) < 60) begin
          wr_req[i] = 1'b1;
          set_writer(i, rand_x(), rand_y(), 24'($urandom));
        end else begin
          wr_req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    vid_req = 1'b0;
    wr_req  = 2'b00;
  endtask

  initial begin
    vid_req = 0; vid_x = 0; vid_y = 0;
    wr_req = 0; wr_x = 0; wr_y = 0; wr_data = 0;
    we_seen = 0;
    obs_gnt = 0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = pat(i);
    m_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // in-range video read of a preloaded pixel
    vid_req = 1; vid_x = 3; vid_y = 2;
    step();
    chk("t1_addr", mem_addr, 323);
    vid_req = 0;
    step();
    chk("t1_valid", vid_valid, 1);
    chk("t1_rgb", {vid_r, vid_g, vid_b}, 24'h123456);

    // out-of-range video read returns black
    vid_req = 1; vid_x = 160; vid_y = 0;
    step();
    vid_req = 0;
    step();
    chk("t2_valid", vid_valid, 1);
    chk("t2_rgb", {vid_r, vid_g, vid_b}, 0);

    // writer stalls through active video
    vid_req = 1; vid_x = 20; vid_y = 30;
    wr_req = 2'b01;
    set_writer(0, 5, 6, 24'hA1B2C3);
    repeat (10) step();
    vid_req = 0;
    step();
    chk("t3_gnt", obs_gnt, 2'b01);
    chk("t3_we", mem_we, 1);
    chk("t3_addr", mem_addr, 6 * 160 + 5);
    chk("t3_wdata", mem_wdata, 24'hA1B2C3);
    wr_req = 2'b00;
    repeat (3) step();

    // randomized mixed traffic
    repeat (2000) begin
      drive_random();
      step();
    end
    idle_inputs();
    repeat (3) step();

    // out-of-range writes are granted, dropped and counted to saturation
    wr_req = 2'b01;
    set_writer(0, 200, 5, 24'h777777);
    we_seen = 0;
    repeat (65539) step();
    chk("drop_sat", drop_cnt, 16'hFFFF);
    chk("drop_no_we", we_seen, 0);
    wr_req = 2'b00;
    step();

    // reset with a read in flight
    vid_req = 1; vid_x = 10; vid_y = 10;
    step();
    vid_req = 0;
    wr_req  = 2'b11;
    #1;
    reset = 1'b0;
    #1;
    check_zero("midrst");
    m_reset();
    @(posedge clk);
    wr_req = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step();

    // both writers back-to-back: alternation starting from port0
    wr_req = 2'b11;
    set_writer(0, 1, 1, 24'h010101);
    set_writer(1, 2, 2, 24'h020202);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_gnt", obs_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      for (int i = 0; i < 2; i++)
        if (last_gnt[i]) set_writer(i, rand_x() % 160, rand_y() % 120, 24'($urandom));
    end
    wr_req = 2'b00;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
